// File: rtl/spw_rx_pkg.sv
// spw_rx_pkg: shared SpaceWire receive constants, control codes and decoder state encoding.
package spw_rx_pkg;
  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b01;
  localparam logic [1:0] CODE_EEP = 2'b10;
  localparam logic [1:0] CODE_ESC = 2'b11;
  localparam logic [6:0] NULL_PATTERN = 7'b1110100;
  localparam logic [8:0] DATA_EOP = 9'h100;
  localparam logic [8:0] DATA_EEP = 9'h101;
  typedef enum logic [1:0] {ST_HUNT, ST_RUN, ST_ERROR} state_e;
endpackage

// File: rtl/rx_ds_bit_recover.sv
// rx_ds_bit_recover: registers D/S, flags bit events on D^S changes and times link silence.
module rx_ds_bit_recover #(
  parameter int DISCONNECT_CYCLES = 85,
  parameter int DISC_CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic din,
  input  logic sin,
  output logic bit_event,
  output logic bit_val,
  output logic disconnect
);
  localparam logic [DISC_CNT_W-1:0] CNT_MAX = DISC_CNT_W'(DISCONNECT_CYCLES);
  logic din_q, din_d, sin_q, sin_d, xor_q, xor_d, seen_q, seen_d;
  logic [DISC_CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    din_d = din;
    sin_d = sin;
    xor_d = din_q ^ sin_q;
    bit_event = xor_d != xor_q;
    bit_val = din_q;
    seen_d = enable & (seen_q | bit_event);
    cnt_d = (!enable || bit_event) ? '0 : (seen_q && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    disconnect = enable & (cnt_q == CNT_MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
      sin_q <= 1'b0;
      xor_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      din_q <= din_d;
      sin_q <= sin_d;
      xor_q <= xor_d;
      seen_q <= seen_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rx_char_decode.sv
// rx_char_decode: hunts for NULL, then frames, parity-checks and decodes SpaceWire characters.
module rx_char_decode
  import spw_rx_pkg::*;
#(
  parameter int DISCONNECT_CYCLES = 85,
  parameter int DISC_CNT_W = 8
) (
  input  logic       pclk_rx,
  input  logic       reset_rx,
  input  logic       rx_enable,
  input  logic       rx_din,
  input  logic       rx_sin,
  output logic       rx_got_null,
  output logic       rx_got_fct,
  output logic       rx_got_data,
  output logic [8:0] rx_data,
  output logic       rx_got_time_code,
  output logic [7:0] rx_time_out,
  output logic       rx_error_parity,
  output logic       rx_error_esc,
  output logic       rx_error_disconnect
);
  logic bit_event, bit_val, disconnect, last;
  state_e state_q, state_d;
  logic [6:0] win_q, win_d;
  logic [7:0] sh_q, sh_d, sh_n, time_q, time_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] data_q, data_d;
  logic flag_q, flag_d, pbit_q, pbit_d, acc_q, acc_d, acc_n, par_q, par_d, esc_q, esc_d;
  logic null_q, null_d, fct_q, fct_d, dat_q, dat_d, tc_q, tc_d;
  logic e_par_q, e_par_d, e_esc_q, e_esc_d, e_disc_q, e_disc_d;

  rx_ds_bit_recover #(.DISCONNECT_CYCLES(DISCONNECT_CYCLES), .DISC_CNT_W(DISC_CNT_W)) u_bit (
    .clk(pclk_rx), .rst(reset_rx), .enable(rx_enable), .din(rx_din), .sin(rx_sin),
    .bit_event(bit_event), .bit_val(bit_val), .disconnect(disconnect)
  );

  always_comb begin
    state_d = state_q;
    win_d = win_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    flag_d = flag_q;
    pbit_d = pbit_q;
    acc_d = acc_q;
    par_d = par_q;
    esc_d = esc_q;
    data_d = data_q;
    time_d = time_q;
    null_d = 1'b0;
    fct_d = 1'b0;
    dat_d = 1'b0;
    tc_d = 1'b0;
    e_par_d = e_par_q;
    e_esc_d = e_esc_q;
    e_disc_d = e_disc_q;
    sh_n = {bit_val, sh_q[7:1]};
    acc_n = acc_q ^ bit_val;
    last = flag_q ? cnt_q == 4'd3 : cnt_q == 4'd9;
    if (!rx_enable) begin
      state_d = state_q == ST_ERROR ? ST_ERROR : ST_HUNT;
      win_d = '0;
      cnt_d = '0;
      esc_d = 1'b0;
    end else begin
      if (state_q == ST_HUNT && bit_event) begin
        win_d = {win_q[5:0], bit_val};
        if (win_d == NULL_PATTERN) begin
          null_d = 1'b1;
          par_d = 1'b0;
          cnt_d = '0;
          esc_d = 1'b0;
          state_d = ST_RUN;
        end
      end else if (state_q == ST_RUN && bit_event) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd0) pbit_d = bit_val;
        else if (cnt_q == 4'd1) begin
          flag_d = bit_val;
          acc_d = 1'b0;
          if (!(par_q ^ pbit_q ^ bit_val)) begin
            e_par_d = 1'b1;
            state_d = ST_ERROR;
          end
        end else begin
          sh_d = sh_n;
          acc_d = acc_n;
          if (last) begin
            cnt_d = '0;
            par_d = acc_n;
            esc_d = 1'b0;
            if (flag_q) begin
              // After two shifts the control bits sit at [7:6] as {c1,c0}
              if (sh_n[7:6] == CODE_FCT) begin
                null_d = esc_q;
                fct_d = !esc_q;
              end else if (esc_q) begin
                e_esc_d = 1'b1;
                state_d = ST_ERROR;
              end else if (sh_n[7:6] == CODE_ESC) esc_d = 1'b1;
              else begin
                dat_d = 1'b1;
                data_d = sh_n[7:6] == CODE_EOP ? DATA_EOP : DATA_EEP;
              end
            end else if (esc_q) begin
              tc_d = 1'b1;
              time_d = sh_n;
            end else begin
              dat_d = 1'b1;
              data_d = {1'b0, sh_n};
            end
          end
        end
      end
      if (disconnect) begin
        e_disc_d = 1'b1;
        state_d = ST_ERROR;
      end
    end
  end

  always_ff @(posedge pclk_rx) begin
    if (reset_rx) begin
      state_q <= ST_HUNT;
      win_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      flag_q <= 1'b0;
      pbit_q <= 1'b0;
      acc_q <= 1'b0;
      par_q <= 1'b0;
      esc_q <= 1'b0;
      data_q <= '0;
      time_q <= '0;
      null_q <= 1'b0;
      fct_q <= 1'b0;
      dat_q <= 1'b0;
      tc_q <= 1'b0;
      e_par_q <= 1'b0;
      e_esc_q <= 1'b0;
      e_disc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      flag_q <= flag_d;
      pbit_q <= pbit_d;
      acc_q <= acc_d;
      par_q <= par_d;
      esc_q <= esc_d;
      data_q <= data_d;
      time_q <= time_d;
      null_q <= null_d;
      fct_q <= fct_d;
      dat_q <= dat_d;
      tc_q <= tc_d;
      e_par_q <= e_par_d;
      e_esc_q <= e_esc_d;
      e_disc_q <= e_disc_d;
    end
  end

  assign rx_got_null = null_q;
  assign rx_got_fct = fct_q;
  assign rx_got_data = dat_q;
  assign rx_data = data_q;
  assign rx_got_time_code = tc_q;
  assign rx_time_out = time_q;
  assign rx_error_parity = e_par_q;
  assign rx_error_esc = e_esc_q;
  assign rx_error_disconnect = e_disc_q;
endmodule
